// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if -- Execute-stage bundle between the pipeline and the iterative
// M-extension multiplier (mul_ctrl).
//
// Signals
//   startE    pipeline -> mul  multiply request in Execute
//   funct3E   pipeline -> mul  op select (000 MUL, 001 MULH, 010 MULHSU, 011/1xx MULHU)
//   rdata1E   pipeline -> mul  rs1 operand
//   rdata2E   pipeline -> mul  rs2 operand
//   kill      pipeline -> mul  flush; abandons any in-flight operation
//   StallMul  mul -> pipeline  hold Fetch/Decode/Execute registers
//   busy      mul -> pipeline  multiplier is not idle
//   done      mul -> pipeline  one-cycle pulse, result valid
//   result    mul -> pipeline  selected 32-bit product word
//   dbg_state mul -> observer  FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a request is accepted on a rising edge where the multiplier is
// idle, startE=1 and kill=0. While it is in flight StallMul holds the pipeline
// so startE/operands stay stable; StallMul drops in the done cycle, letting
// the instruction advance with result on the same edge.
interface mul_ctrl_if;
  logic        startE;
  logic [2:0]  funct3E;
  logic [31:0] rdata1E;
  logic [31:0] rdata2E;
  logic        kill;
  logic        StallMul;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  modport master (
    output startE, funct3E, rdata1E, rdata2E, kill,
    input  StallMul, busy, done, result, dbg_state
  );

  modport slave (
    input  startE, funct3E, rdata1E, rdata2E, kill,
    output StallMul, busy, done, result, dbg_state
  );
endinterface

// File: rtl/mul_ctrl.sv
// mul_ctrl -- iterative radix-2 shift-add multiplier for RV32 MUL/MULH/
// MULHSU/MULHU. Multiplies operand magnitudes into a 64-bit accumulator, one
// multiplier bit per cycle, then applies the sign correction in DONE.
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-low reset (0 = reset)
//   bus  mul_ctrl_if.slave (request, operands, kill, stall/busy/done/result,
//        FSM state for observation)
//
// Build option
//   MUL_CTRL_EARLY_EXIT_EN  when defined, RUN ends as soon as the remaining
//                           multiplier bits are all zero (at least one step).
//                           Otherwise every operation takes 32 RUN cycles.
module mul_ctrl (
  input  logic       clk,
  input  logic       rst,
  mul_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q;
  logic [63:0] acc_q;
  logic [63:0] mcand_q;     // multiplicand magnitude, shifted left each step
  logic [31:0] mplier_q;    // multiplier magnitude, shifted right each step
  logic        neg_q;       // exactly one operand negative
  logic        op_lo_q;     // MUL selects the low word
  logic [31:0] result_q;

  logic        accept;
  logic        last_step;
  logic        stall_c;
  logic        busy_c;
  logic        done_c;

  // Operand decode. rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH.
  logic        signed_a, signed_b;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    signed_a = ~bus.funct3E[2] & ~(bus.funct3E[1] & bus.funct3E[0]);
    signed_b = ~bus.funct3E[2] & ~bus.funct3E[1];
    a_neg    = signed_a & bus.rdata1E[31];
    b_neg    = signed_b & bus.rdata2E[31];
    // 0x80000000 negates to itself, which read unsigned is the correct 2^31.
    mag_a    = a_neg ? (~bus.rdata1E + 32'd1) : bus.rdata1E;
    mag_b    = b_neg ? (~bus.rdata2E + 32'd1) : bus.rdata2E;
  end

  assign accept = bus.startE & ~bus.kill;

`ifdef MUL_CTRL_EARLY_EXIT_EN
  // After this step only mplier_q[31:1] remains; nothing left to add if zero.
  assign last_step = (count_q == 5'd31) | (mplier_q[31:1] == 31'd0);
`else
  assign last_step = (count_q == 5'd31);
`endif

  // Datapath helpers.
  logic [63:0] acc_step;
  logic [63:0] product;
  logic [31:0] product_word;

  assign acc_step     = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign product      = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign product_word = op_lo_q ? product[31:0] : product[63:32];

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state and outputs.
  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          stall_c = 1'b1;
        end
      end
      RUN: begin
        busy_c  = 1'b1;
        stall_c = 1'b1;
        if (bus.kill)       state_d = IDLE;
        else if (last_step) state_d = DONE;
      end
      DONE: begin
        busy_c  = 1'b1;
        done_c  = ~bus.kill;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= 5'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      neg_q    <= 1'b0;
      op_lo_q  <= 1'b0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            count_q  <= 5'd0;
            acc_q    <= 64'd0;
            mcand_q  <= {32'd0, mag_a};
            mplier_q <= mag_b;
            neg_q    <= a_neg ^ b_neg;
            op_lo_q  <= (bus.funct3E == 3'b000);
          end
        end
        RUN: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 5'd1;
        end
        DONE: begin
          if (done_c) result_q <= product_word;
        end
        default: ;
      endcase
    end
  end

  // The new word is shown in the done cycle itself and held afterwards; a
  // kill in DONE leaves the previous word visible.
  assign bus.result    = done_c ? product_word : result_q;
  assign bus.done      = done_c;
  assign bus.busy      = busy_c;
  // Gated by rst so a held startE cannot stall the pipeline during reset.
  assign bus.StallMul  = rst & stall_c;
  assign bus.dbg_state = state_q;

endmodule
